// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - hh:mm:ss sequencer with CPU load and button setting
// Optional CLOCK_SET_12H_EN: adds pm and presents hours as 1..12.
module clock_set_ctrl #(
  parameter int SET_TIMEOUT = 30
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [14:0] set_word,
  input  logic        tick_1hz,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [4:0]  hours,
  output logic [5:0]  minutes,
  output logic [5:0]  seconds,
  output logic [1:0]  setting,
  output logic        load_done,
`ifdef CLOCK_SET_12H_EN
  output logic        pm,
`endif
  output logic        load_err
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10
  } state_t;

  localparam logic [5:0] TO_LAST = 6'(SET_TIMEOUT - 1);

  state_t     r_state;
  logic [4:0] r_hours;
  logic [5:0] r_minutes;
  logic [5:0] r_seconds;
  logic [5:0] r_to_cnt;
  logic       r_req_q;
  logic       r_load_done;
  logic       r_load_err;

  logic       w_req;
  logic       w_fields_ok;
  logic [4:0] w_hours_inc;
  logic [5:0] w_minutes_inc;
  logic       w_unused_bits;

  assign w_req         = set_word[14] ^ r_req_q;
  assign w_fields_ok   = (set_word[13:9] <= 5'd23) && (set_word[8:3] <= 6'd59);
  assign w_hours_inc   = (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
  assign w_minutes_inc = (r_minutes == 6'd59) ? 6'd0 : r_minutes + 6'd1;
  assign w_unused_bits = ^set_word[2:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_RUN;
      r_hours     <= 5'd0;
      r_minutes   <= 6'd0;
      r_seconds   <= 6'd0;
      r_to_cnt    <= 6'd0;
      r_req_q     <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_req_q     <= set_word[14];
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      if (w_req && w_fields_ok) begin
        // An accepted CPU load wins outright: same-cycle buttons and tick are dropped.
        r_hours     <= set_word[13:9];
        r_minutes   <= set_word[8:3];
        r_seconds   <= 6'd0;
        r_state     <= ST_RUN;
        r_to_cnt    <= 6'd0;
        r_load_done <= 1'b1;
      end else begin
        if (w_req) begin
          r_load_err <= 1'b1;
        end
        if (btn_mode) begin
          r_to_cnt <= 6'd0;
          case (r_state)
            ST_RUN:    r_state <= ST_SET_HR;
            ST_SET_HR: r_state <= ST_SET_MIN;
            default: begin
              r_state   <= ST_RUN;
              r_seconds <= 6'd0;
            end
          endcase
        end else if (btn_inc) begin
          r_to_cnt <= 6'd0;
          if (r_state == ST_SET_HR) begin
            r_hours <= w_hours_inc;
          end else if (r_state == ST_SET_MIN) begin
            r_minutes <= w_minutes_inc;
          end
        end else if (tick_1hz) begin
          if (r_state == ST_RUN) begin
            if (r_seconds == 6'd59) begin
              r_seconds <= 6'd0;
              r_minutes <= w_minutes_inc;
              if (r_minutes == 6'd59) begin
                r_hours <= w_hours_inc;
              end
            end else begin
              r_seconds <= r_seconds + 6'd1;
            end
          end else if (r_to_cnt == TO_LAST) begin
            // Idle too long while setting: leave setting mode, time untouched.
            r_state  <= ST_RUN;
            r_to_cnt <= 6'd0;
          end else begin
            r_to_cnt <= r_to_cnt + 6'd1;
          end
        end
      end
    end
  end

`ifdef CLOCK_SET_12H_EN
  assign hours = (r_hours == 5'd0)  ? 5'd12 :
                 (r_hours > 5'd12)  ? r_hours - 5'd12 : r_hours;
  assign pm    = (r_hours >= 5'd12);
`else
  assign hours = r_hours;
`endif
  assign minutes   = r_minutes;
  assign seconds   = r_seconds;
  assign setting   = r_state;
  assign load_done = r_load_done;
  assign load_err  = r_load_err;

endmodule
